// File: rtl/sevenseg_capture.sv
// Watches a multiplexed active-low seven-segment bus and recovers the BCD code shown
// on each digit position, with stability qualification, frame tracking and sticky errors.
module sevenseg_capture #(
  parameter int NDIG          = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          seg_n,
  input  logic [NDIG-1:0]     an_n,
  input  logic                clr_err,
  output logic [4*NDIG-1:0]   digits,
  output logic [NDIG-1:0]     digit_valid,
  output logic                frame_done,
  output logic                err_invalid,
  output logic                err_anode,
  output logic [1:0]          fsm_state
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic [6:0]      seg_q, seg_p;
  logic [NDIG-1:0] an_q, an_p;
  logic [NDIG-1:0] act;
  logic            one_hot, multi, same, accept;
  logic [IW-1:0]   pos;
  logic [3:0]      code;
  logic [NDIG-1:0] seen, seen_acc;

  assign act     = ~an_q;
  assign one_hot = (act != '0) && ((act & (act - NDIG'(1))) == '0);
  assign multi   = (act != '0) && !one_hot;
  assign same    = (seg_q == seg_p) && (an_q == an_p);
  assign seen_acc  = seen | (NDIG'(1) << pos);
  assign fsm_state = state;

  // Input registers park on blank / no anode so the first real sample never matches.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      seg_p <= 7'h7F;
      an_q  <= '1;
      an_p  <= '1;
    end else begin
      seg_q <= seg_n;
      seg_p <= seg_q;
      an_q  <= an_n;
      an_p  <= an_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    accept   = 1'b0;
    if (!one_hot) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_nx = TRACK;
          cnt_nx   = CNT_ONE;
        end
        TRACK: begin
          if (!same) begin
            cnt_nx = CNT_ONE;
          end else if (cnt == CNT_LAST) begin
            accept   = 1'b1;
            state_nx = HOLD;
            cnt_nx   = cnt + CNT_ONE;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        HOLD: begin
          if (!same) begin
            state_nx = TRACK;
            cnt_nx   = CNT_ONE;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_comb begin
    pos = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (act[i]) pos = IW'(i);
    end
  end

  always_comb begin
    case (seg_q)
      7'b1000000: code = 4'd0;
      7'b1111001: code = 4'd1;
      7'b0100100: code = 4'd2;
      7'b0110000: code = 4'd3;
      7'b0011001: code = 4'd4;
      7'b0010010: code = 4'd5;
      7'b0000010: code = 4'd6;
      7'b1111000: code = 4'd7;
      7'b0000000: code = 4'd8;
      7'b0011000: code = 4'd9;
      7'b1111111: code = 4'hF;
      default:    code = 4'hE;
    endcase
  end

  // Error flags: set wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      digits      <= '0;
      digit_valid <= '0;
      frame_done  <= 1'b0;
      err_invalid <= 1'b0;
      err_anode   <= 1'b0;
      seen        <= '0;
    end else begin
      frame_done <= 1'b0;
      if (accept) begin
        digits[4*pos +: 4] <= code;
        digit_valid[pos]   <= 1'b1;
        if (seen_acc == '1) begin
          seen       <= '0;
          frame_done <= 1'b1;
        end else begin
          seen <= seen_acc;
        end
      end
      err_invalid <= (err_invalid & ~clr_err) | (accept && (code == 4'hE));
      err_anode   <= (err_anode & ~clr_err) | multi;
    end
  end

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: directed scenarios plus a randomized run, all checked
// against a run-length reference model of the bus as the capture block sees it.
module tb_sevenseg_capture;

  localparam int NDIG = 4;
  localparam int S    = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [6:0]       seg_n = 7'h7F;
  logic [NDIG-1:0]  an_n = '1;
  logic             clr_err = 1'b0;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]  digit_valid;
  logic             frame_done, err_invalid, err_anode;
  logic [1:0]       fsm_state;

  int n_checks = 0;
  int n_err    = 0;

  sevenseg_capture #(.NDIG(NDIG), .STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg_n(seg_n), .an_n(an_n), .clr_err(clr_err),
    .digits(digits), .digit_valid(digit_valid), .frame_done(frame_done),
    .err_invalid(err_invalid), .err_anode(err_anode), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                               7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};

  function automatic logic [3:0] ref_decode(input logic [6:0] s);
    ref_decode = (s == 7'h7F) ? 4'hF : 4'hE;
    for (int d = 0; d < 10; d++) if (seg_tab[d] == s) ref_decode = 4'(d);
  endfunction

  logic [4*NDIG-1:0] m_digits;
  logic [NDIG-1:0]   m_valid, m_seen;
  logic              m_frame, m_err_inv, m_err_an;
  int                run_len, pend_pos;
  logic [6:0]        prev_seg;
  logic [NDIG-1:0]   prev_an;
  logic              pend_acc, pend_multi;
  logic [3:0]        pend_code;

  // Effects of a sample become visible one edge after the model sees it on the pins.
  always @(posedge clk) begin
    if (reset) begin
      m_digits = '0; m_valid = '0; m_seen = '0; m_frame = 0; m_err_inv = 0; m_err_an = 0;
      run_len = 0; prev_seg = 7'h7F; prev_an = '1; pend_acc = 0; pend_multi = 0;
      pend_pos = 0; pend_code = 0;
    end else begin
      m_frame = 0;
      if (clr_err) begin m_err_inv = 0; m_err_an = 0; end
      if (pend_multi) m_err_an = 1;
      if (pend_acc) begin
        m_digits[4*pend_pos +: 4] = pend_code;
        m_valid[pend_pos] = 1;
        if (pend_code == 4'hE) m_err_inv = 1;
        m_seen[pend_pos] = 1;
        if (m_seen == '1) begin m_frame = 1; m_seen = '0; end
      end
      pend_multi = ($countones(~an_n) > 1);
      if ($countones(~an_n) == 1) begin
        if (run_len > 0 && seg_n == prev_seg && an_n == prev_an) run_len++;
        else run_len = 1;
      end else begin
        run_len = 0;
      end
      pend_acc  = (run_len == S);
      pend_code = ref_decode(seg_n);
      for (int i = 0; i < NDIG; i++) if (!an_n[i]) pend_pos = i;
      prev_seg = seg_n;
      prev_an  = an_n;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input logic [6:0] s, input logic [NDIG-1:0] a, input logic c);
    seg_n = s; an_n = a; clr_err = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(7'h7F, '1, 1'b0);
    tick(7'h7F, '1, 1'b0);
    reset = 1'b0;
  endtask

  function automatic logic [NDIG-1:0] an_of(input int p);
    an_of = ~(NDIG'(1) << p);
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_checks++;
    if ({digits, digit_valid, frame_done, err_invalid, err_anode} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs got %h/%b/%b/%b/%b want all zero",
               digits, digit_valid, frame_done, err_invalid, err_anode);
    end
    n_checks++;
    if (fsm_state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", fsm_state); end
  endtask

  task automatic test_hold();
    logic [NDIG-1:0] ev;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      tick(7'b0100100, 4'b1110, 1'b0);
      ev = (k >= S + 1) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (digit_valid !== ev) begin
        n_err++; $display("FAIL hold_valid tick %0d got %b want %b", k, digit_valid, ev);
      end
      n_checks++;
      if (digits !== ((k >= S + 1) ? 16'h0002 : 16'h0000)) begin
        n_err++; $display("FAIL hold_digits tick %0d got %h", k, digits);
      end
      n_checks++;
      if (frame_done !== 1'b0) begin n_err++; $display("FAIL hold_frame tick %0d got 1 want 0", k); end
    end
  endtask

  // Scans positions 0..NDIG-1, 6 ticks each, showing digit p+1; returns pulse count and index.
  task automatic scan(input int npos, input int nlast, output int pulses, output int at);
    int idx = 0;
    pulses = 0; at = -1;
    for (int p = 0; p < npos; p++) begin
      for (int k = 0; k < ((p == npos - 1) ? nlast : 6); k++) begin
        tick(seg_tab[p + 1], an_of(p), 1'b0);
        if (frame_done === 1'b1) begin pulses++; at = idx; end
        n_checks++;
        if ({digits, digit_valid, frame_done} !== {m_digits, m_valid, m_frame}) begin
          n_err++;
          $display("FAIL scan_model idx %0d got %h/%b/%b want %h/%b/%b", idx,
                   digits, digit_valid, frame_done, m_digits, m_valid, m_frame);
        end
        idx++;
      end
    end
  endtask

  task automatic test_scan();
    int pulses, at;
    do_reset();
    scan(4, 6, pulses, at);
    n_checks++;
    if (pulses !== 1 || at !== 22) begin
      n_err++; $display("FAIL scan_frame got %0d pulses at %0d want 1 at 22", pulses, at);
    end
    n_checks++;
    if (digits !== 16'h4321 || digit_valid !== 4'b1111) begin
      n_err++; $display("FAIL scan_final got %h/%b want 4321/1111", digits, digit_valid);
    end
  endtask

  task automatic test_unstable();
    do_reset();
    for (int k = 0; k < 3; k++) tick(7'b0110000, 4'b1101, 1'b0);
    n_checks++;
    if (digit_valid !== 4'b0000 || digits !== 16'h0) begin
      n_err++; $display("FAIL unstable_short got %h/%b want 0000/0000", digits, digit_valid);
    end
    for (int k = 1; k <= S + 1; k++) begin
      tick(7'b0011001, 4'b1101, 1'b0);
      n_checks++;
      if (digit_valid !== ((k == S + 1) ? 4'b0010 : 4'b0000)) begin
        n_err++; $display("FAIL unstable_restart tick %0d got %b", k, digit_valid);
      end
    end
    n_checks++;
    if (digits !== 16'h0040) begin n_err++; $display("FAIL unstable_digits got %h want 0040", digits); end
  endtask

  task automatic test_invalid();
    do_reset();
    for (int k = 0; k < 5; k++) tick(7'b1111111, 4'b1101, 1'b0);
    n_checks++;
    if (digits[7:4] !== 4'hF || err_invalid !== 1'b0) begin
      n_err++; $display("FAIL blank_code got %h err %b want F err 0", digits[7:4], err_invalid);
    end
    for (int k = 0; k < 5; k++) tick(7'b0101010, 4'b1101, 1'b0);
    n_checks++;
    if (digits[7:4] !== 4'hE || err_invalid !== 1'b1) begin
      n_err++; $display("FAIL bad_code got %h err %b want E err 1", digits[7:4], err_invalid);
    end
    for (int k = 0; k < 3; k++) tick(7'h7F, 4'b1111, 1'b0);
    n_checks++;
    if (err_invalid !== 1'b1) begin n_err++; $display("FAIL invalid_sticky got 0 want 1"); end
    tick(7'h7F, 4'b1111, 1'b1);
    n_checks++;
    if (err_invalid !== 1'b0) begin n_err++; $display("FAIL invalid_clear got 1 want 0"); end
  endtask

  task automatic test_anode_err();
    do_reset();
    tick(7'b0000000, 4'b1110, 1'b0);
    tick(7'b0000000, 4'b1110, 1'b0);
    n_checks++;
    if (fsm_state !== 2'd1) begin n_err++; $display("FAIL anode_track got %0d want 1", fsm_state); end
    tick(7'h7F, 4'b1100, 1'b0);
    n_checks++;
    if (err_anode !== 1'b0) begin n_err++; $display("FAIL anode_early got 1 want 0"); end
    tick(7'h7F, 4'b1111, 1'b0);
    n_checks++;
    if (err_anode !== 1'b1 || fsm_state !== 2'd0) begin
      n_err++; $display("FAIL anode_set got err %b state %0d want 1/0", err_anode, fsm_state);
    end
    tick(7'h7F, 4'b1100, 1'b0);
    tick(7'h7F, 4'b1100, 1'b1);
    n_checks++;
    if (err_anode !== 1'b1) begin n_err++; $display("FAIL anode_setwins got 0 want 1"); end
    tick(7'h7F, 4'b1111, 1'b0);
    tick(7'h7F, 4'b1111, 1'b1);
    n_checks++;
    if (err_anode !== 1'b0) begin n_err++; $display("FAIL anode_clear got 1 want 0"); end
  endtask

  task automatic test_anode_change();
    do_reset();
    for (int k = 0; k < 3; k++) tick(7'b0000000, 4'b1110, 1'b0);
    for (int k = 0; k < 3; k++) tick(7'b0000000, 4'b1101, 1'b0);
    tick(7'h7F, 4'b1111, 1'b0);
    tick(7'h7F, 4'b1111, 1'b0);
    n_checks++;
    if (digit_valid !== 4'b0000) begin
      n_err++; $display("FAIL anode_change got %b want 0000", digit_valid);
    end
  endtask

  task automatic test_reset_mid();
    int pulses, at;
    do_reset();
    scan(4, 4, pulses, at);
    do_reset();
    n_checks++;
    if ({digits, digit_valid, frame_done, err_invalid, err_anode} !== '0) begin
      n_err++; $display("FAIL midreset_outputs got %h/%b/%b want zero", digits, digit_valid, frame_done);
    end
    tick(7'h7F, 4'b1111, 1'b0);
    n_checks++;
    if (frame_done !== 1'b0) begin n_err++; $display("FAIL midreset_pending got 1 want 0"); end
    scan(4, 6, pulses, at);
    n_checks++;
    if (pulses !== 1 || at !== 22) begin
      n_err++; $display("FAIL midreset_frame got %0d pulses at %0d want 1 at 22", pulses, at);
    end
  endtask

  task automatic test_random();
    logic [6:0]      s;
    logic [NDIG-1:0] a;
    int r, len;
    do_reset();
    for (int run = 0; run < 400; run++) begin
      r = $urandom_range(0, 11);
      s = (r < 10) ? seg_tab[r] : (r == 10) ? 7'h7F : 7'($urandom);
      r = $urandom_range(0, 9);
      if (r == 0)      a = '1;
      else if (r == 1) a = ~(an_of(0) ^ an_of($urandom_range(1, NDIG - 1)));
      else             a = an_of($urandom_range(0, NDIG - 1));
      len = $urandom_range(1, 7);
      for (int k = 0; k < len; k++) begin
        tick(s, a, ($urandom_range(0, 7) == 0));
        n_checks++;
        if ({digits, digit_valid, frame_done, err_invalid, err_anode} !==
            {m_digits, m_valid, m_frame, m_err_inv, m_err_an}) begin
          n_err++;
          $display("FAIL random run %0d got %h/%b/%b/%b/%b want %h/%b/%b/%b/%b", run,
                   digits, digit_valid, frame_done, err_invalid, err_anode,
                   m_digits, m_valid, m_frame, m_err_inv, m_err_an);
        end
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_hold();
    test_scan();
    test_unstable();
    test_invalid();
    test_anode_err();
    test_anode_change();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
